// File: rtl/dm_mem_if.sv
// ----------------------------------------------------------------------------
// dm_mem_if
//   Bundle of the MEM-stage data-memory signals exchanged between the pipeline
//   (EX/MEM register side) and the data memory block.
//
//   master : pipeline side, drives the request and reads back results
//   slave  : data memory side (dm_mem_stage)
//
//   MemWrM      store request this cycle
//   MemToRegM   load request this cycle (only used for the AdEL check)
//   storeselM   store size: 00 word, 01 half, 10 byte, 11 word
//   loadselM    load size:  00 word, 01 half, 10 byte, 11 word
//   ALUOutM     byte address
//   WriteDataM  store data, right-aligned
//   ExcFlushM   exception/interrupt in MEM, suppresses the store
//   PC_M        PC of the MEM-stage instruction (store log only)
//   ReadDataM   raw addressed word
//   AdEL_M      misaligned load
//   AdES_M      misaligned store
//   dm_busy     post-reset clear sweep in progress (pipeline stall)
// ----------------------------------------------------------------------------
interface dm_mem_if;
  logic        MemWrM;
  logic        MemToRegM;
  logic [1:0]  storeselM;
  logic [1:0]  loadselM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic        ExcFlushM;
  logic [31:0] PC_M;
  logic [31:0] ReadDataM;
  logic        AdEL_M;
  logic        AdES_M;
  logic        dm_busy;

  modport master (
    output MemWrM, MemToRegM, storeselM, loadselM, ALUOutM, WriteDataM,
           ExcFlushM, PC_M,
    input  ReadDataM, AdEL_M, AdES_M, dm_busy
  );

  modport slave (
    input  MemWrM, MemToRegM, storeselM, loadselM, ALUOutM, WriteDataM,
           ExcFlushM, PC_M,
    output ReadDataM, AdEL_M, AdES_M, dm_busy
  );
endinterface

// File: rtl/dm_mem_stage.sv
// ----------------------------------------------------------------------------
// dm_mem_stage
//   MEM-stage data memory of the 5-stage MIPS pipeline. Word, halfword and
//   byte stores with byte enables; loads return the raw addressed word (the WB
//   stage extends it). Misaligned loads/stores raise AdEL_M/AdES_M. After
//   reset a sweep FSM (CLEAR -> RUN) zeroes every word, holding dm_busy high
//   so the hazard unit stalls the front of the pipeline meanwhile.
//
//   Parameter DEPTH_LOG2 : log2 of the number of 32-bit words (10 -> 4 KB)
//
//   Ports:
//     clk    pipeline clock, rising edge
//     reset  asynchronous active-low reset
//     bus    dm_mem_if.slave (request, address, data, results, dm_busy)
//
//   Optional macro DM_WRITE_LOG_EN: when defined, every committed store is
//   printed as "<time>@<pc>: *<word address> <= <merged word>". The hardware
//   behaviour is identical with or without it.
// ----------------------------------------------------------------------------
module dm_mem_stage #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic    clk,
  input  logic    reset,
  dm_mem_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Size codes: 01 half, 10 byte, anything else (00, 11) is a word.
  function automatic logic misaligned_f(input logic [1:0] sel,
                                        input logic [1:0] lo);
    logic mis;
    case (sel)
      2'b01:   mis = lo[0];
      2'b10:   mis = 1'b0;
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_en_f(input logic [1:0] sel,
                                           input logic [1:0] lo);
    logic [3:0] be;
    case (sel)
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b0001 << lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Halfwords go to both halves and bytes to all four lanes, so the byte
  // enables alone select which lane lands in memory.
  function automatic logic [31:0] lanes_f(input logic [1:0]  sel,
                                          input logic [31:0] wd);
    logic [31:0] ln;
    case (sel)
      2'b01:   ln = {wd[15:0], wd[15:0]};
      2'b10:   ln = {4{wd[7:0]}};
      default: ln = wd;
    endcase
    return ln;
  endfunction

  state_t                state_r;
  state_t                state_nxt_s;
  logic [DEPTH_LOG2-1:0] cnt_r;
  logic [31:0]           mem_r [DEPTH];

  logic                  run_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic [31:0]           rd_word_s;
  logic                  ades_s;
  logic                  adel_s;
  logic [3:0]            be_s;
  logic [31:0]           lanes_s;
  logic [31:0]           merged_s;
  logic                  commit_s;
  logic                  wr_en_s;
  logic [DEPTH_LOG2-1:0] wr_idx_s;
  logic [31:0]           wr_data_s;

  // Upper address bits wrap the memory; PC_M only feeds the optional log.
  logic unused_s;
  assign unused_s = ^{bus.PC_M, bus.ALUOutM[31:DEPTH_LOG2+2]};

  assign run_s     = (state_r == RUN);
  assign idx_s     = bus.ALUOutM[DEPTH_LOG2+1:2];
  assign rd_word_s = mem_r[idx_s];

  // Misalignment checks, store byte enables and the merged store word.
  always_comb begin
    ades_s   = run_s & bus.MemWrM
               & misaligned_f(bus.storeselM, bus.ALUOutM[1:0]);
    adel_s   = run_s & bus.MemToRegM
               & misaligned_f(bus.loadselM, bus.ALUOutM[1:0]);
    be_s     = byte_en_f(bus.storeselM, bus.ALUOutM[1:0]);
    lanes_s  = lanes_f(bus.storeselM, bus.WriteDataM);
    merged_s = rd_word_s;
    for (int b = 0; b < 4; b++) begin
      merged_s[8*b +: 8] = be_s[b] ? lanes_s[8*b +: 8] : rd_word_s[8*b +: 8];
    end
    commit_s = run_s & bus.MemWrM & ~ades_s & ~bus.ExcFlushM;
  end

  // Write port mux: the sweep owns the port in CLEAR, stores own it in RUN.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = '0;
    wr_data_s = 32'h0000_0000;
    if (run_s) begin
      wr_en_s   = commit_s;
      wr_idx_s  = idx_s;
      wr_data_s = merged_s;
    end else begin
      // No sweep writes while reset is held; the counter is parked at 0.
      wr_en_s   = reset;
      wr_idx_s  = cnt_r;
      wr_data_s = 32'h0000_0000;
    end
  end

  // Memory array write (no reset: contents are cleared by the sweep).
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= wr_data_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: leave CLEAR on the edge that clears the last word.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      CLEAR: begin
        if (cnt_r == LAST_IDX) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = CLEAR;
    endcase
  end

  // Sweep counter: advances once per cleared word, restarts on every reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (state_r == CLEAR) begin
      cnt_r <= cnt_r + DEPTH_LOG2'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.dm_busy   = ~run_s;
  assign bus.ReadDataM = run_s ? rd_word_s : 32'h0000_0000;
  assign bus.AdES_M    = ades_s;
  assign bus.AdEL_M    = adel_s;

`ifdef DM_WRITE_LOG_EN
  // Store trace: word-aligned address and the full word after the write.
  always_ff @(posedge clk) begin
    if (reset && commit_s) begin
      $display("%d@%h: *%h <= %h", $time, bus.PC_M,
               {bus.ALUOutM[31:2], 2'b00}, merged_s);
    end
  end
`endif

endmodule

// File: tb/tb_dm_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_dm_mem_stage
//   Self-checking bench for dm_mem_stage. The reference model is a plain
//   byte-addressed array of 4096 bytes: a store of N bytes writes N
//   consecutive little-endian bytes, an access is misaligned when the address
//   is not a multiple of its size, and addresses wrap modulo 4 KB.
// ----------------------------------------------------------------------------
module tb_dm_mem_stage;

  logic clk = 1'b0;
  logic reset;

  dm_mem_if bus();

  dm_mem_stage #(.DEPTH_LOG2(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [4096];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [1:0] sel);
    case (sel)
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic misal(input logic [1:0] sel, input logic [31:0] addr);
    return (addr % size_of(sel)) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int base;
    base = int'(addr & 32'h0000_0FFC);
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] sel);
    int a;
    a = int'(addr & 32'h0000_0FFF);
    for (int i = 0; i < size_of(sel); i++) begin
      ref_mem[a+i] = 8'(data >> (8*i));
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
  endtask

  // One pipeline cycle: drive after the falling edge, check the combinational
  // outputs against the model, then let the next rising edge commit.
  task automatic op(input string tag, input logic wr, input logic rd,
                    input logic [1:0] ssel, input logic [1:0] lsel,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic flush);
    @(negedge clk);
    bus.MemWrM     = wr;
    bus.MemToRegM  = rd;
    bus.storeselM  = ssel;
    bus.loadselM   = lsel;
    bus.ALUOutM    = addr;
    bus.WriteDataM = wdata;
    bus.ExcFlushM  = flush;
    bus.PC_M       = 32'h0040_0000 + 32'(checks);
    #1;
    check({tag, "/rdata"}, bus.ReadDataM, ref_word(addr));
    check({tag, "/ades"}, {31'b0, bus.AdES_M}, {31'b0, wr & misal(ssel, addr)});
    check({tag, "/adel"}, {31'b0, bus.AdEL_M}, {31'b0, rd & misal(lsel, addr)});
    if (wr && !misal(ssel, addr) && !flush) ref_store(addr, wdata, ssel);
  endtask

  task automatic rd_op(input string tag, input logic [31:0] addr);
    op(tag, 1'b0, 1'b0, 2'b00, 2'b00, addr, 32'h0, 1'b0);
  endtask

  // Counts cycles with dm_busy high after a release at a falling edge.
  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    while (bus.dm_busy === 1'b1 && cnt < 2000) begin
      cnt++;
      if (cnt == 10) begin
        #1;
        check({tag, "/clr_rdata"}, bus.ReadDataM, 32'h0);
        check({tag, "/clr_ades"}, {31'b0, bus.AdES_M}, 32'h0);
        check({tag, "/clr_adel"}, {31'b0, bus.AdEL_M}, 32'h0);
        // Aligned store to word 0 for the rest of the sweep: must be ignored.
        bus.ALUOutM = 32'h0000_0000;
      end
      @(negedge clk);
    end
    bus.MemWrM    = 1'b0;
    bus.MemToRegM = 1'b0;
    check({tag, "/busy_cycles"}, 32'(cnt), 32'd1024);
  endtask

  initial begin
    logic [31:0] addr;

    reset          = 1'b0;
    bus.MemWrM     = 1'b1;
    bus.MemToRegM  = 1'b1;
    bus.storeselM  = 2'b00;
    bus.loadselM   = 2'b00;
    bus.ALUOutM    = 32'h0000_0023;
    bus.WriteDataM = 32'hFFFF_FFFF;
    bus.ExcFlushM  = 1'b0;
    bus.PC_M       = 32'h0040_0000;

    repeat (3) @(negedge clk);
    #1;
    check("rst/busy", {31'b0, bus.dm_busy}, 32'h1);
    check("rst/rdata", bus.ReadDataM, 32'h0);
    check("rst/ades", {31'b0, bus.AdES_M}, 32'h0);
    check("rst/adel", {31'b0, bus.AdEL_M}, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    count_busy("sweep1");
    ref_clear();

    rd_op("rd_ffc", 32'h0000_0FFC);
    check("plan_ffc_zero", bus.ReadDataM, 32'h0);
    rd_op("rd_0", 32'h0000_0000);

    op("sw10", 1'b1, 1'b0, 2'b00, 2'b00, 32'h10, 32'h1234_5678, 1'b0);
    op("sh12", 1'b1, 1'b0, 2'b01, 2'b00, 32'h12, 32'h0000_ABCD, 1'b0);
    op("sb11", 1'b1, 1'b0, 2'b10, 2'b00, 32'h11, 32'h0000_00EE, 1'b0);
    rd_op("rd10", 32'h10);
    check("plan_abcdee78", bus.ReadDataM, 32'hABCD_EE78);

    op("sw_wrap", 1'b1, 1'b0, 2'b00, 2'b00, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0);
    rd_op("rd4", 32'h4);
    check("plan_wrap", bus.ReadDataM, 32'hDEAD_BEEF);

    op("sw22", 1'b1, 1'b0, 2'b00, 2'b00, 32'h22, 32'h1111_1111, 1'b0);
    check("plan_ades22", {31'b0, bus.AdES_M}, 32'h1);
    rd_op("rd20", 32'h20);
    check("plan_nowrite22", bus.ReadDataM, 32'h0);
    op("lh13", 1'b0, 1'b1, 2'b00, 2'b01, 32'h13, 32'h0, 1'b0);
    check("plan_adel_lh13", {31'b0, bus.AdEL_M}, 32'h1);
    op("lb13", 1'b0, 1'b1, 2'b00, 2'b10, 32'h13, 32'h0, 1'b0);
    check("plan_adel_lb13", {31'b0, bus.AdEL_M}, 32'h0);
    op("both13", 1'b1, 1'b1, 2'b11, 2'b01, 32'h13, 32'h2222_2222, 1'b0);

    op("sw8_flush", 1'b1, 1'b0, 2'b00, 2'b00, 32'h8, 32'h55, 1'b1);
    op("sw8", 1'b1, 1'b0, 2'b00, 2'b00, 32'h8, 32'h55, 1'b0);
    check("plan_flush_kept", bus.ReadDataM, 32'h0);
    rd_op("rd8", 32'h8);
    check("plan_after_flush", bus.ReadDataM, 32'h0000_0055);

    for (int i = 0; i < 400; i++) begin
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFF_F000);
      op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), addr, $urandom,
         ($urandom_range(0, 9) == 0));
    end
    for (int a = 0; a < 64; a += 4) rd_op("readback", 32'(a));

    // Mid-sweep reset with data held at the top word.
    op("sw_top", 1'b1, 1'b0, 2'b00, 2'b00, 32'hFFC, 32'hCAFE_F00D, 1'b0);
    rd_op("rd_top", 32'hFFC);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst2/busy", {31'b0, bus.dm_busy}, 32'h1);
    check("rst2/rdata", bus.ReadDataM, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (500) @(negedge clk);
    check("mid/busy", {31'b0, bus.dm_busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("mid/busy_rst", {31'b0, bus.dm_busy}, 32'h1);
    repeat (2) @(negedge clk);
    bus.MemWrM    = 1'b1;
    bus.MemToRegM = 1'b1;
    bus.ALUOutM   = 32'h0000_0023;
    reset = 1'b1;
    count_busy("sweep2");
    ref_clear();
    for (int a = 0; a < 64; a += 4) rd_op("clr_readback", 32'(a));
    rd_op("clr_top", 32'hFFC);
    check("plan_top_cleared", bus.ReadDataM, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_mem_stage.md
Name: dm_mem_stage

Overview:
- MEM-stage data memory of the 5-stage MIPS pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Performs word, halfword and byte stores with byte-enables.
- Provides the raw addressed word for loads; sign/zero extension of loads is done in the WB stage.
- Flags misaligned accesses (AdEL/AdES) and clears its RAM with a post-reset sweep FSM that stalls the pipeline while it runs.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words (10 gives 4 KB).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemWrM  input  1  store request this cycle.
- MemToRegM  input  1  load request this cycle (used only for AdEL).
- storeselM  input  2  store size: 00 word, 01 half, 10 byte, 11 treated as word.
- loadselM  input  2  load size: 00 word, 01 half, 10 byte, 11 treated as word.
- ALUOutM  input  32  byte address.
- WriteDataM  input  32  store data, right-aligned.
- ExcFlushM  input  1  exception/interrupt in MEM this cycle; suppresses the store.
- PC_M  input  32  PC of the MEM-stage instruction (logging only).
- ReadDataM  output  32  raw addressed word.
- AdEL_M  output  1  load address misaligned.
- AdES_M  output  1  store address misaligned.
- dm_busy  output  1  clear sweep in progress; hazard unit stalls PC/IF/ID/EX and clears EX/MEM while high.

Behaviour:
- FSM states: CLEAR and RUN.
- While reset is low (asynchronous): state=CLEAR, sweep counter=0, dm_busy=1, ReadDataM=0, AdEL_M=0, AdES_M=0.
- CLEAR, after reset goes high: each rising edge writes 0 to mem[counter], then counter++. On the edge that writes index 2^DEPTH_LOG2-1, state becomes RUN. dm_busy is therefore high for exactly 2^DEPTH_LOG2 cycles after reset release; the first RUN cycle follows.
- reset low mid-sweep: counter restarts at 0; words already cleared stay cleared.
- In CLEAR: all store requests are ignored; ReadDataM=0; AdEL_M=AdES_M=0.
- RUN:
  - Word index = ALUOutM[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo the memory size.
  - AdES_M (combinational) = MemWrM & ((word & ALUOutM[1:0]!=0) | (half & ALUOutM[0])).
  - AdEL_M (combinational) = MemToRegM & the same rule applied to loadselM.
  - Byte-enable: word 1111; half ALUOutM[1] ? 1100 : 0011; byte 0001<<ALUOutM[1:0].
  - Store lanes: halfword is replicated to both halves, byte to all four lanes; only enabled bytes change.
  - Store commits at the rising edge iff MemWrM & !AdES_M & !ExcFlushM & RUN. A misaligned or flushed store leaves memory unchanged.
  - ReadDataM = mem[index], combinational.
  - Read of an index written at the same edge: returns the old word before the edge, the new word after it.
  - MemWrM and MemToRegM both high is legal; the two checks are independent.

Optional Feature:
- Macro: DM_WRITE_LOG_EN.
- Defined: on every committed store, $display "%d@%h: *%h <= %h" with $time, PC_M, {ALUOutM[31:2],2'b00} and the full merged 32-bit word after the write.
- Not defined: no display; PC_M is unused.
- RTL behaviour is identical in both cases.

Test Plan:
- Reset low 3 cycles, then high -> dm_busy=1 for exactly 1024 cycles, then 0. Reading any address (e.g. 0x0000_0FFC) gives 0x0000_0000.
- RUN: sw 0x12345678 @0x10, then sh 0xABCD @0x12, then sb 0xEE @0x11 -> ReadDataM @0x10 = 0xABCDEE78.
- sw 0xDEADBEEF @0x0000_1004 -> wraps to index 1; ReadDataM @0x4 = 0xDEADBEEF.
- sw @0x22 -> AdES_M=1 and no write. lh request @0x13 -> AdEL_M=1. lb @0x13 -> AdEL_M=0.
- sw 0x55 @0x8 with ExcFlushM=1 -> mem[0x8] unchanged (0). Next cycle with ExcFlushM=0 -> 0x00000055.
- reset low at sweep cycle 500 after memory held data -> counter restarts; dm_busy high for a further 1024 cycles after release; all words read 0.
